md5_result_unload: RTL and testbench

MD5_RESULT_UNLOAD -- requirements
Module: md5_result_unload

---
 rtl/md5_result_unload.sv | 90 +++++++++
 tb/tb_md5_result_unload.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/md5_result_unload.sv
// Collects WORDS 32-bit result words, then emits them as 16-bit halfwords,
// low half first. A sticky err flag records writes while busy or reads while empty.
module md5_result_unload #(
  parameter int WORDS = 4
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] din,
  output logic        ready,
  output logic [15:0] dout,
  output logic        empty,
  input  logic        rd_en,
  output logic        err
);

  localparam int WCW = $clog2(WORDS + 1);
  localparam int HCW = $clog2(2 * WORDS + 1);
  localparam int SW  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {LOAD, UNLOAD} state_t;

  state_t          state;
  logic [WCW-1:0]  wcnt;
  logic [HCW-1:0]  hcnt;
  logic [SW:0]     hnext;
  logic [31:0]     nword;
  logic [31:0]     slots [2**SW];

  always_comb begin
    ready = (state == LOAD);
    empty = (state != UNLOAD);
  end

  // Next halfword index splits into word select (upper bits) and half select (bit 0).
  always_comb begin
    hnext = hcnt[SW:0] + 1'b1;
    nword = slots[hnext[SW:1]];
  end

  always_ff @(posedge CLK) begin
    if (!rst && state == LOAD && wr_en)
      slots[wcnt[SW-1:0]] <= din;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= LOAD;
      wcnt  <= '0;
      hcnt  <= '0;
      dout  <= '0;
      err   <= 1'b0;
    end else begin
      if (wr_en && state != LOAD)
        err <= 1'b1;
      if (rd_en && state != UNLOAD)
        err <= 1'b1;

      case (state)
        LOAD: begin
          if (wr_en) begin
            if (wcnt == WCW'(WORDS - 1)) begin
              state <= UNLOAD;
              wcnt  <= '0;
              hcnt  <= '0;
              // With a single word, slot 0 is being written this very cycle.
              dout  <= (wcnt == '0) ? din[15:0] : slots[0][15:0];
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        UNLOAD: begin
          if (rd_en) begin
            if (hcnt == HCW'(2 * WORDS - 1)) begin
              state <= LOAD;
              hcnt  <= '0;
              dout  <= '0;
            end else begin
              hcnt <= hcnt + 1'b1;
              dout <= hnext[0] ? nword[31:16] : nword[15:0];
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_result_unload.sv
// Scoreboard bench for md5_result_unload, exercising a WORDS=4 and a WORDS=1 instance.
module tb_md5_result_unload;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        wr_en [2];
  logic        rd_en [2];
  logic [31:0] din   [2];
  logic        ready [2];
  logic        empty [2];
  logic        err   [2];
  logic [15:0] dout  [2];

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  logic [15:0] exp_q [2][$];
  logic [31:0] words [2][$];
  int unsigned remaining [2];
  bit          m_err [2];

  md5_result_unload #(.WORDS(4)) dut4 (
    .CLK(clk), .rst(rst[0]), .wr_en(wr_en[0]), .din(din[0]), .ready(ready[0]),
    .dout(dout[0]), .empty(empty[0]), .rd_en(rd_en[0]), .err(err[0])
  );

  md5_result_unload #(.WORDS(1)) dut1 (
    .CLK(clk), .rst(rst[1]), .wr_en(wr_en[1]), .din(din[1]), .ready(ready[1]),
    .dout(dout[1]), .empty(empty[1]), .rd_en(rd_en[1]), .err(err[1])
  );

  function automatic int unsigned wof(input int unsigned k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Reference model: a result is a list of words; once complete it becomes a
  // list of 2*WORDS halfwords that must be drained before loading resumes.
  always @(posedge clk) begin
    for (int unsigned k = 0; k < 2; k++) begin
      automatic bit busy = (remaining[k] != 0);
      if (rst[k]) begin
        exp_q[k].delete();
        words[k].delete();
        remaining[k] = 0;
        m_err[k] = 1'b0;
      end else begin
        if (wr_en[k]) begin
          if (busy) m_err[k] = 1'b1;
          else begin
            words[k].push_back(din[k]);
            if (words[k].size() == wof(k)) begin
              foreach (words[k][i]) begin
                exp_q[k].push_back(words[k][i][15:0]);
                exp_q[k].push_back(words[k][i][31:16]);
              end
              words[k].delete();
              remaining[k] = 2 * wof(k);
            end
          end
        end
        if (rd_en[k]) begin
          if (busy) remaining[k] = remaining[k] - 1;
          else m_err[k] = 1'b1;
        end
      end
    end
  end

  task automatic check(input int unsigned k, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL w%0d %s at %0t: got %h expected %h", wof(k), nm, $time, act, exp);
    end
  endtask

  // Monitor: mid-cycle, compare flags against the model and pop on each handshake.
  always @(negedge clk) begin
    if (started) begin
      for (int unsigned k = 0; k < 2; k++) begin
        check(k, "ready", 32'(ready[k]), 32'(remaining[k] == 0));
        check(k, "empty", 32'(empty[k]), 32'(remaining[k] == 0));
        check(k, "err",   32'(err[k]),   32'(m_err[k]));
        if (!empty[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w%0d dout_unexpected at %0t: got %h expected none", wof(k), $time, dout[k]);
          end else begin
            check(k, "dout", 32'(dout[k]), 32'(exp_q[k][0]));
            if (rd_en[k]) void'(exp_q[k].pop_front());
          end
        end else begin
          check(k, "dout_idle", 32'(dout[k]), 32'h0);
        end
      end
    end
  end

  task automatic step(input int unsigned k, input logic r, input logic w,
                      input logic [31:0] d, input logic rd);
    rst[k] = r; wr_en[k] = w; din[k] = d; rd_en[k] = rd;
    @(posedge clk); #1;
    rst[k] = 1'b0; wr_en[k] = 1'b0; rd_en[k] = 1'b0;
  endtask

  function automatic logic [31:0] v27(input int unsigned i, input int unsigned w);
    return (w == 1) ? 32'h0000FFFF : 32'h11112222 + 32'(i % 4) * 32'h22222222;
  endfunction

  task automatic load_fixed(input int unsigned k);
    for (int unsigned i = 0; i < wof(k); i++) step(k, 0, 1, v27(i, wof(k)), 0);
  endtask

  task automatic load_rand(input int unsigned k);
    for (int unsigned i = 0; i < wof(k); i++) step(k, 0, 1, $urandom, 0);
  endtask

  task automatic read_all(input int unsigned k);
    for (int unsigned i = 0; i < 2 * wof(k); i++) step(k, 0, 0, 0, 1);
  endtask

  task automatic run(input int unsigned k);
    automatic int unsigned w = wof(k);
    // read while empty, then clear the sticky flag
    step(k, 0, 0, 0, 1);
    step(k, 0, 0, 0, 0);
    step(k, 1, 0, 0, 0);
    // streaming load and drain
    load_fixed(k);
    read_all(k);
    step(k, 0, 0, 0, 0);
    step(k, 0, 0, 0, 0);
    // throttled drain
    load_fixed(k);
    for (int unsigned i = 0; i < 2 * w; i++) begin
      step(k, 0, 0, 0, 1);
      step(k, 0, 0, 0, 0);
    end
    // write while unloading, also on the final read cycle
    load_rand(k);
    step(k, 0, 1, 32'hDEADBEEF, 0);
    for (int unsigned i = 0; i + 1 < 2 * w; i++) step(k, 0, 0, 0, 1);
    step(k, 0, 1, 32'hCAFEF00D, 1);
    load_rand(k);
    read_all(k);
    step(k, 1, 0, 0, 0);
    // abort a partial load
    for (int unsigned i = 0; i < ((w > 1) ? 2 : 0); i++) step(k, 0, 1, $urandom, 0);
    step(k, 1, 1, 32'h12345678, 1);
    load_rand(k);
    read_all(k);
    // abort a partial unload
    load_rand(k);
    for (int unsigned i = 0; i < ((2 * w - 1 < 3) ? 2 * w - 1 : 3); i++) step(k, 0, 0, 0, 1);
    step(k, 1, 0, 0, 0);
    for (int unsigned i = 0; i < w; i++) step(k, 0, 1, 32'hAAAABBBB, 0);
    read_all(k);
    // random traffic with occasional resets
    for (int unsigned n = 0; n < 300; n++)
      step(k, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 2) != 0);
    step(k, 1, 0, 0, 0);
    step(k, 0, 0, 0, 0);
  endtask

  initial begin
    for (int unsigned k = 0; k < 2; k++) begin
      rst[k] = 1'b1; wr_en[k] = 1'b0; rd_en[k] = 1'b0; din[k] = '0;
      remaining[k] = 0; m_err[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    started = 1'b1;
    run(0);
    run(1);
    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
